// File: rtl/ysyx_22040750_ifu.sv
// Instruction fetch unit: one outstanding memory request, one-entry instruction buffer.
// Latency: buffer valid 1 cycle after the response beat; requests stall while the buffer is full and not draining.
module ysyx_22040750_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        I_sys_clk,
  input  logic        I_rst,
  input  logic        I_redirect,
  input  logic [63:0] I_redirect_pc,
  output logic        O_req_valid,
  input  logic        I_req_ready,
  output logic [63:0] O_req_addr,
  input  logic        I_rsp_valid,
  input  logic [31:0] I_rsp_data,
  output logic        O_inst_valid,
  input  logic        I_inst_ready,
  output logic [31:0] O_inst,
  output logic [63:0] O_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_e;

  state_e      state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] redirect_tgt;
  logic        req_fire;

  assign redirect_tgt = I_redirect_pc & ~64'h3;

  // A request is only offered when the buffer will have room for its response.
  assign O_req_valid  = (state_q == REQ) && (!inst_valid_q || I_inst_ready);
  assign O_req_addr   = fetch_pc_q;
  assign req_fire     = O_req_valid && I_req_ready;

  assign O_inst_valid = inst_valid_q;
  assign O_inst       = inst_q;
  assign O_pc         = pc_q;

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    inst_valid_d = inst_valid_q;
    inst_d       = inst_q;
    pc_d         = pc_q;

    if (inst_valid_q && I_inst_ready) begin
      inst_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (req_fire) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (I_rsp_valid) begin
          state_d      = REQ;
          inst_valid_d = 1'b1;
          inst_d       = I_rsp_data;
          pc_d         = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + 64'd4;
        end
      end
      DROP: begin
        if (I_rsp_valid) begin
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase

    if (I_redirect) begin
      fetch_pc_d   = redirect_tgt;
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      pc_d         = pc_q;
      case (state_q)
        IDLE:    state_d = REQ;
        REQ:     state_d = req_fire ? DROP : REQ;
        WAIT:    state_d = I_rsp_valid ? REQ : DROP;
        // The beat being dropped may land in the same cycle; then nothing is left in flight.
        DROP:    state_d = I_rsp_valid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge I_sys_clk or negedge I_rst) begin
    if (!I_rst) begin
      state_q      <= IDLE;
      fetch_pc_q   <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      pc_q         <= 64'h0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
    end
  end

endmodule
